// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage.
// WORD_SIZE and the opcode macros normally come from top_macro.vh; the
// guarded defaults below keep this slice self-contained when it is absent.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADD
`define ADD 5'b00000
`endif
`ifndef SUB
`define SUB 5'b00001
`endif
`ifndef COMP
`define COMP 5'b00010
`endif

package alu_writeback_pkg;

    // Result-buffer occupancy states
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } wb_state_e;

    // Bit positions inside the flags output {sticky_ovf, greater, equal}
    localparam int unsigned FlagEqBit  = 0;
    localparam int unsigned FlagGtBit  = 1;
    localparam int unsigned FlagOvfBit = 2;

    localparam int unsigned OpcodeW = 5;
    localparam int unsigned CompW   = 2;

    // Opcodes that retire into the register file
    function automatic logic is_write_op(input logic [OpcodeW-1:0] op);
        return (op == `ADD) || (op == `SUB);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry result buffer with an EMPTY/ONE/FULL occupancy FSM.
// Drains one entry per cycle, oldest first, whenever not empty and not stalled.

module wb_fifo
    import alu_writeback_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [Width-1:0] push_data_i,
    input  logic             stall_i,
    output logic             pop_valid_o,
    output logic [Width-1:0] pop_data_o
);

    wb_state_e        state_q, state_d;
    logic             ready_q;
    logic             wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [2];
    logic             push, pop;

    assign push = push_valid_i & ready_q;
    assign pop  = (state_q != StEmpty) & ~stall_i;

    // Occupancy moves by one on push-only or pop-only; push+pop holds it
    always_comb begin
        state_d = state_q;
        case ({push, pop})
            2'b10:   state_d = (state_q == StEmpty) ? StOne : StFull;
            2'b01:   state_d = (state_q == StFull) ? StOne : StEmpty;
            default: state_d = state_q;
        endcase
    end

    // FSM, pointers, storage and the registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            ready_q  <= 1'b1;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFull);
            if (push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign push_ready_o = ready_q;
    assign pop_valid_o  = pop;
    assign pop_data_o   = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers ALU results, retires ADD/SUB into the register
// file, COMP into the equal/greater flags, and keeps a sticky overflow bit.
// Optional macro WB_BYPASS_EN forwards the draining entry to the read ports.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef COMP
`define COMP 5'b00010
`endif

module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter  int unsigned NREGS = 8,
    localparam int unsigned AddrW = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [OpcodeW-1:0]    res_opcode_i,
    input  logic [`WORD_SIZE-1:0] res_data_i,
    input  logic                  res_overflow_i,
    input  logic [CompW-1:0]      res_comp_flag_i,
    input  logic [AddrW-1:0]      res_rd_i,
    input  logic                  wb_stall_i,
    input  logic [AddrW-1:0]      rs1_addr_i,
    input  logic [AddrW-1:0]      rs2_addr_i,
    output logic [`WORD_SIZE-1:0] rs1_data_o,
    output logic [`WORD_SIZE-1:0] rs2_data_o,
    output logic [2:0]            flags_o,
    input  logic                  clr_ovf_i
);

    localparam int unsigned EntryW = OpcodeW + `WORD_SIZE + 1 + CompW + AddrW;

    logic [EntryW-1:0]     push_data, pop_data;
    logic                  pop_valid;
    logic [OpcodeW-1:0]    dr_op;
    logic [`WORD_SIZE-1:0] dr_data;
    logic                  dr_ovf;
    logic [CompW-1:0]      dr_cf;
    logic [AddrW-1:0]      dr_rd;
    logic                  drain_wr, drain_cmp, reg_we;

    logic [`WORD_SIZE-1:0] regs_q [NREGS];
    logic [2:0]            flags_q, flags_d;

    assign push_data = {res_opcode_i, res_data_i, res_overflow_i, res_comp_flag_i, res_rd_i};

    wb_fifo #(
        .Width (EntryW)
    ) u_wb_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (res_valid_i),
        .push_ready_o (res_ready_o),
        .push_data_i  (push_data),
        .stall_i      (wb_stall_i),
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data)
    );

    assign {dr_op, dr_data, dr_ovf, dr_cf, dr_rd} = pop_data;

    assign drain_wr  = pop_valid & is_write_op(dr_op);
    assign drain_cmp = pop_valid & (dr_op == `COMP);
    // Register 0 is hardwired to zero, so its writes are dropped here
    assign reg_we    = drain_wr & (dr_rd != '0);

    // Register file write on drain of ADD/SUB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[dr_rd] <= dr_data;
        end
    end

    // Flag next state; clr_ovf wins over an overflow arriving the same cycle
    always_comb begin
        flags_d = flags_q;
        if (clr_ovf_i) begin
            flags_d[FlagOvfBit] = 1'b0;
        end else if (drain_wr && dr_ovf) begin
            flags_d[FlagOvfBit] = 1'b1;
        end
        if (drain_cmp) begin
            flags_d[FlagEqBit] = dr_cf[0];
            flags_d[FlagGtBit] = dr_cf[1];
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

    // Read port 1
    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
`ifdef WB_BYPASS_EN
        if (reg_we && (rs1_addr_i == dr_rd)) begin
            rs1_data_o = dr_data;
        end
`endif
    end

    // Read port 2
    always_comb begin
        rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
`ifdef WB_BYPASS_EN
        if (reg_we && (rs2_addr_i == dr_rd)) begin
            rs2_data_o = dr_data;
        end
`endif
    end

endmodule
